// File: rtl/mult_div_unit_pkg.sv
// Shared MDU operation codes, FSM states and stall-control usage classes.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MDU_OP_NONE  = 4'd0,
    MDU_OP_MULT  = 4'd1,
    MDU_OP_MULTU = 4'd2,
    MDU_OP_DIV   = 4'd3,
    MDU_OP_DIVU  = 4'd4,
    MDU_OP_MFHI  = 4'd5,
    MDU_OP_MFLO  = 4'd6,
    MDU_OP_MTHI  = 4'd7,
    MDU_OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Stall control groups MDU ops by how they touch HI/LO.
  typedef enum logic [1:0] {
    SCU_MDU_USAGE_NONE  = 2'd0,
    SCU_MDU_USAGE_CALC  = 2'd1,
    SCU_MDU_USAGE_READ  = 2'd2,
    SCU_MDU_USAGE_WRITE = 2'd3
  } scu_mdu_usage_e;

  localparam int CNT_W = 4;

  function automatic logic mdu_is_start(input logic [3:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic scu_mdu_usage_e mdu_usage(input logic [3:0] op);
    if (mdu_is_start(op)) return SCU_MDU_USAGE_CALC;
    if ((op == MDU_OP_MFHI) || (op == MDU_OP_MFLO)) return SCU_MDU_USAGE_READ;
    if ((op == MDU_OP_MTHI) || (op == MDU_OP_MTLO)) return SCU_MDU_USAGE_WRITE;
    return SCU_MDU_USAGE_NONE;
  endfunction

endpackage

// File: rtl/mdu_result_calc.sv
// Combinational MDU arithmetic: full 64-bit {HI,LO} result for the sampled
// operands, plus a flag telling the sequencer a divide had a zero divisor.
module mdu_result_calc
  import mult_div_unit_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        div_zero_o
);

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] a_zx, b_zx, prod_u;
  logic        [31:0] b_safe;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;
  logic               b_zero, div_ovf;

  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign a_zx   = {32'd0, a_i};
  assign b_zx   = {32'd0, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // A zero divisor is replaced by 1 so the dividers never see it; the flag
  // suppresses the commit instead.
  assign b_zero = (b_i == 32'd0);
  assign b_safe = b_zero ? 32'd1 : b_i;
  assign quo_s  = $signed(a_i) / $signed(b_safe);
  assign rem_s  = $signed(a_i) % $signed(b_safe);
  assign quo_u  = a_i / b_safe;
  assign rem_u  = a_i % b_safe;
  assign div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  always_comb begin
    result_o   = 64'd0;
    div_zero_o = 1'b0;
    case (op_i)
      MDU_OP_MULT:  result_o = prod_s;
      MDU_OP_MULTU: result_o = prod_u;
      MDU_OP_DIV: begin
        div_zero_o = b_zero;
        if (div_ovf) result_o = {32'd0, 32'h8000_0000};
        else         result_o = {rem_s, quo_s};
      end
      MDU_OP_DIVU: begin
        div_zero_o = b_zero;
        result_o   = {rem_u, quo_u};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: multi-cycle MULT/DIV sequencing with Busy,
// architectural HI/LO, and MFHI/MFLO/MTHI/MTLO handling.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  MDU_i_Op,
  input  logic [31:0] MDU_i_A,
  input  logic [31:0] MDU_i_B,
  input  logic        MDU_i_Req,
  output logic        MDU_o_Busy,
  output logic [31:0] MDU_o_Out
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;
  logic [63:0]      calc_result;
  logic             calc_dz;
  logic             accept;

  mdu_result_calc u_calc (
    .op_i       (MDU_i_Op),
    .a_i        (MDU_i_A),
    .b_i        (MDU_i_B),
    .result_o   (calc_result),
    .div_zero_o (calc_dz)
  );

  assign accept = (state_q == ST_IDLE) && !MDU_i_Req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && mdu_is_start(MDU_i_Op)) begin
          state_d   = ST_RUN;
          cnt_d     = mdu_is_div(MDU_i_Op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_hi_d = calc_result[63:32];
          pend_lo_d = calc_result[31:0];
          pend_dz_d = calc_dz;
        end else if (accept && (MDU_i_Op == MDU_OP_MTHI)) begin
          hi_d = MDU_i_A;
        end else if (accept && (MDU_i_Op == MDU_OP_MTLO)) begin
          lo_d = MDU_i_A;
        end
      end
      ST_RUN: begin
        // The last counted cycle commits; a zero divisor leaves HI/LO alone.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign MDU_o_Busy = (state_q == ST_RUN);

  always_comb begin
    MDU_o_Out = 32'd0;
    if (MDU_i_Op == MDU_OP_MFHI)      MDU_o_Out = hi_q;
    else if (MDU_i_Op == MDU_OP_MFLO) MDU_o_Out = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        req;
  logic        busy;
  logic [31:0] out;

  int vectors;
  int errors;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .MDU_i_Op   (op),
    .MDU_i_A    (a),
    .MDU_i_B    (b),
    .MDU_i_Req  (req),
    .MDU_o_Busy (busy),
    .MDU_o_Out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
    op = o; a = av; b = bv;
    step();
    op = MDU_OP_NONE; a = '0; b = '0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    logic [3:0] saved;
    saved = op;
    op = MDU_OP_MFHI; #1; hi = out;
    op = MDU_OP_MFLO; #1; lo = out;
    op = saved;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; op = MDU_OP_MFHI; a = '0; b = '0; req = 1'b0;
    step(); step();
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++;
    if (out !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 00000000", out); end
    op = MDU_OP_MFLO; #1;
    vectors++;
    if (out !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 00000000", out); end
    op = MDU_OP_NONE; #1;
    vectors++;
    if (out !== 32'd0) begin errors++; $display("FAIL out_none got %h want 00000000", out); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_mt();
    logic [31:0] hi, lo;
    issue(MDU_OP_MTHI, 32'hCAFE_0001, 32'd0);
    issue(MDU_OP_MTLO, 32'hBEEF_0002, 32'd0);
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'hCAFE_0001) begin errors++; $display("FAIL mthi got %h want cafe0001", hi); end
    vectors++;
    if (lo !== 32'hBEEF_0002) begin errors++; $display("FAIL mtlo got %h want beef0002", lo); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mt_busy got %0b want 0", busy); end
  endtask

  task automatic test_mult();
    logic [31:0] hi, lo;
    int n;
    issue(MDU_OP_MULT, 32'hFFFF_FFFE, 32'd3);
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'hCAFE_0001) begin errors++; $display("FAIL mult_hi_during_run got %h want cafe0001", hi); end
    wait_idle(n);
    vectors++;
    if (n != 5) begin errors++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    vectors++;
    if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", lo); end
  endtask

  task automatic test_multu();
    logic [31:0] hi, lo;
    int n;
    issue(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    vectors++;
    if (n != 5) begin errors++; $display("FAIL multu_busy_cycles got %0d want 5", n); end
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    vectors++;
    if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
  endtask

  task automatic test_div();
    logic [31:0] hi, lo;
    int n;
    issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    vectors++;
    if (n != 10) begin errors++; $display("FAIL div_busy_cycles got %0d want 10", n); end
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
    vectors++;
    if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
  endtask

  task automatic test_div_overflow();
    logic [31:0] hi, lo;
    int n;
    issue(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    vectors++;
    if (hi !== 32'h0000_0000) begin errors++; $display("FAIL divovf_hi got %h want 00000000", hi); end
  endtask

  task automatic test_divu_zero();
    logic [31:0] hi, lo;
    int n;
    issue(MDU_OP_MTHI, 32'h0000_1234, 32'd0);
    issue(MDU_OP_MTLO, 32'h0000_5678, 32'd0);
    issue(MDU_OP_DIVU, 32'd5, 32'd0);
    wait_idle(n);
    vectors++;
    if (n != 10) begin errors++; $display("FAIL divu0_busy_cycles got %0d want 10", n); end
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'h0000_1234) begin errors++; $display("FAIL divu0_hi got %h want 00001234", hi); end
    vectors++;
    if (lo !== 32'h0000_5678) begin errors++; $display("FAIL divu0_lo got %h want 00005678", lo); end
  endtask

  task automatic test_req();
    logic [31:0] hi, lo;
    req = 1'b1;
    issue(MDU_OP_MULT, 32'd9, 32'd9);
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL req_busy got %0b want 0", busy); end
    issue(MDU_OP_MTHI, 32'hDEAD_DEAD, 32'd0);
    req = 1'b0;
    step();
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'h0000_1234) begin errors++; $display("FAIL req_hi got %h want 00001234", hi); end
    vectors++;
    if (lo !== 32'h0000_5678) begin errors++; $display("FAIL req_lo got %h want 00005678", lo); end
  endtask

  task automatic test_mtlo_during_run();
    logic [31:0] hi, lo;
    int n;
    issue(MDU_OP_MULTU, 32'd6, 32'd7);
    issue(MDU_OP_MTLO, 32'h0000_AAAA, 32'd0);
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'h0000_5678) begin errors++; $display("FAIL run_mtlo_lo_mid got %h want 00005678", lo); end
    wait_idle(n);
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'd42) begin errors++; $display("FAIL run_mtlo_lo got %h want 0000002a", lo); end
    vectors++;
    if (hi !== 32'd0) begin errors++; $display("FAIL run_mtlo_hi got %h want 00000000", hi); end
  endtask

  task automatic test_req_during_run();
    logic [31:0] hi, lo;
    int n;
    issue(MDU_OP_MULT, 32'd3, 32'd4);
    req = 1'b1;
    step();
    req = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reqrun_busy got %0b want 1", busy); end
    wait_idle(n);
    vectors++;
    if (n != 4) begin errors++; $display("FAIL reqrun_remaining got %0d want 4", n); end
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'd12) begin errors++; $display("FAIL reqrun_lo got %h want 0000000c", lo); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    int n;
    issue(MDU_OP_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_idle(n);
    issue(MDU_OP_DIV, 32'd7, 32'hFFFF_FFFE);
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'd1 || lo !== 32'd0) begin
      errors++; $display("FAIL b2b_first got %h_%h want 00000001_00000000", hi, lo);
    end
    wait_idle(n);
    vectors++;
    if (n != 10) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 10", n); end
    read_hilo(hi, lo);
    vectors++;
    if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL b2b_lo got %h want fffffffd", lo); end
    vectors++;
    if (hi !== 32'd1) begin errors++; $display("FAIL b2b_hi got %h want 00000001", hi); end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] hi, lo;
    issue(MDU_OP_DIVU, 32'd100, 32'd7);
    step(); step(); step();
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL rstmid_hilo got %h_%h want 00000000_00000000", hi, lo);
    end
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    read_hilo(hi, lo);
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL rstmid_nocommit got %h_%h want 00000000_00000000", hi, lo);
    end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %0b want 0", busy); end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_mt();
    test_mult();
    test_multu();
    test_div();
    test_div_overflow();
    test_divu_zero();
    test_req();
    test_mtlo_during_run();
    test_req_during_run();
    test_back_to_back();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
